rtc_hms_ctrl: RTL

- Parametrised time-of-day clock core: seconds/minutes/hours counters advanced from a prescaled system clock.
- Provides field-wise manual setting with debounced-edge and auto-repeat increments, a minute-resolution alarm, a 12/24 h display view, and a flattened seconds-of-day count.
- Sits between the board clock/push-buttons and the seven-segment display decoder.

---
 rtl/rtc_hms_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/rtc_hms_ctrl.sv
// Time-of-day clock core: prescaled seconds/minutes/hours, button setting with auto-repeat,
// minute-resolution alarm, 12/24 h display view and a flattened seconds-of-day count.

module rtc_hms_btn #(
  parameter int HOLD_CYC = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_n,
  output logic step
);
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  logic          sync1;
  logic          sync2;
  logic          held_q;
  logic [HW-1:0] hold_cnt;
  logic          repeat_hit;

  // synchroniser holds the "pressed" sense so its cleared state means released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      held_q <= 1'b0;
    end else begin
      sync1  <= ~pin_n;
      sync2  <= sync1;
      held_q <= sync2;
    end
  end

  assign repeat_hit = sync2 && (hold_cnt == HW'(HOLD_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (!sync2 || repeat_hit) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

  assign step = (sync2 && !held_q) || repeat_hit;
endmodule

module rtc_hms_ctrl #(
  parameter int CLK_DIV    = 50000000,
  parameter int HOLD_CYC   = 25000000,
  parameter int ALARM_SECS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        set_en,
  input  logic        inc_s_n,
  input  logic        inc_m_n,
  input  logic        inc_h_n,
  input  logic        mode_12h,
  input  logic        alarm_wr,
  input  logic [4:0]  alarm_h,
  input  logic [5:0]  alarm_m,
  input  logic        alarm_en,
  input  logic        alarm_ack,
  output logic [5:0]  sec,
  output logic [5:0]  min,
  output logic [4:0]  hour,
  output logic [4:0]  hour_disp,
  output logic        pm,
  output logic [16:0] count,
  output logic        tick_1s,
  output logic        day_wrap,
  output logic        alarm
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int AW = $clog2(ALARM_SECS + 1);

  logic [PW-1:0] presc;
  logic          step_s, step_m, step_h;
  logic [5:0]    sec_nxt, min_nxt;
  logic [4:0]    hour_nxt;
  logic [4:0]    alarm_h_q;
  logic [5:0]    alarm_m_q;
  logic [AW-1:0] alarm_left;
  logic          trigger;

  rtc_hms_btn #(.HOLD_CYC(HOLD_CYC)) u_btn_s (.clk(clk), .rst_n(rst_n), .pin_n(inc_s_n), .step(step_s));
  rtc_hms_btn #(.HOLD_CYC(HOLD_CYC)) u_btn_m (.clk(clk), .rst_n(rst_n), .pin_n(inc_m_n), .step(step_m));
  rtc_hms_btn #(.HOLD_CYC(HOLD_CYC)) u_btn_h (.clk(clk), .rst_n(rst_n), .pin_n(inc_h_n), .step(step_h));

  assign tick_1s = run && !set_en && (presc == PW'(CLK_DIV - 1));

  // set mode drops any partial second so the first tick after leaving it is a full second away
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (set_en) begin
      presc <= '0;
    end else if (run) begin
      presc <= tick_1s ? '0 : presc + PW'(1);
    end
  end

  always_comb begin
    sec_nxt  = sec;
    min_nxt  = min;
    hour_nxt = hour;
    day_wrap = 1'b0;
    if (tick_1s) begin
      if (sec == 6'd59) begin
        sec_nxt = 6'd0;
        if (min == 6'd59) begin
          min_nxt = 6'd0;
          if (hour == 5'd23) begin
            hour_nxt = 5'd0;
            day_wrap = 1'b1;
          end else begin
            hour_nxt = hour + 5'd1;
          end
        end else begin
          min_nxt = min + 6'd1;
        end
      end else begin
        sec_nxt = sec + 6'd1;
      end
    end else if (set_en) begin
      // manual steps wrap each field on its own, no carry
      if (step_s) sec_nxt  = (sec == 6'd59)  ? 6'd0 : sec + 6'd1;
      if (step_m) min_nxt  = (min == 6'd59)  ? 6'd0 : min + 6'd1;
      if (step_h) hour_nxt = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec  <= 6'd0;
      min  <= 6'd0;
      hour <= 5'd0;
    end else begin
      sec  <= sec_nxt;
      min  <= min_nxt;
      hour <= hour_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 17'd0;
    end else begin
      count <= 17'(hour) * 17'd3600 + 17'(min) * 17'd60 + 17'(sec);
    end
  end

  always_comb begin
    pm        = (hour >= 5'd12);
    hour_disp = hour;
    if (mode_12h) begin
      if (hour == 5'd0) begin
        hour_disp = 5'd12;
      end else if (hour > 5'd12) begin
        hour_disp = hour - 5'd12;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_h_q <= 5'd0;
      alarm_m_q <= 6'd0;
    end else if (alarm_wr) begin
      alarm_h_q <= (alarm_h > 5'd23) ? 5'd23 : alarm_h;
      alarm_m_q <= (alarm_m > 6'd59) ? 6'd59 : alarm_m;
    end
  end

  // only a running tick can land on the alarm minute; manual setting never triggers
  assign trigger = alarm_en && tick_1s && (sec_nxt == 6'd0) &&
                   (min_nxt == alarm_m_q) && (hour_nxt == alarm_h_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm      <= 1'b0;
      alarm_left <= '0;
    end else if (alarm_ack || !alarm_en) begin
      alarm      <= 1'b0;
      alarm_left <= '0;
    end else if (trigger) begin
      alarm      <= 1'b1;
      alarm_left <= AW'(ALARM_SECS);
    end else if (alarm && tick_1s) begin
      if (alarm_left <= AW'(1)) begin
        alarm      <= 1'b0;
        alarm_left <= '0;
      end else begin
        alarm_left <= alarm_left - AW'(1);
      end
    end
  end
endmodule
